// File: rtl/irq_arbiter_27ch.sv
// irq_arbiter_27ch: 27-channel sticky-pending interrupt arbiter with valid/ack handshake and timeout (IRQ_ARB_ROTATE_EN selects per-bus round-robin)
module irq_arbiter_27ch #(
  parameter int NCH     = 9,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_a,
  input  logic [NCH-1:0] req_b,
  input  logic [NCH-1:0] req_c,
  input  logic [NCH-1:0] en,
  input  logic           irq_ack,
  output logic           irq_valid,
  output logic [1:0]     irq_bus,
  output logic [3:0]     irq_chan,
  output logic           irq_timeout,
  output logic           pend_a,
  output logic           pend_b,
  output logic           pend_c,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, ARB, GRANT, HOLD} state_t;
  state_t state, state_nx;
  logic [NCH-1:0] pa, pb, pc, ca, cb, cc, sel;
  logic [TW-1:0] cnt;
  logic [3:0] win_a, win_b, win_c, w_chan;
  logic [1:0] w_bus;
  logic any, tmo, drop;
  assign any = |pa | |pb | |pc;
  assign tmo = (TIMEOUT != 0) && (cnt == TW'(TIMEOUT - 1));
  assign drop = (state == GRANT) && (irq_ack || tmo);
  assign sel = NCH'(1) << irq_chan;
  assign ca = (drop && irq_bus == 2'd0) ? sel : '0;
  assign cb = (drop && irq_bus == 2'd1) ? sel : '0;
  assign cc = (drop && irq_bus == 2'd2) ? sel : '0;
  assign w_bus = |pa ? 2'd0 : |pb ? 2'd1 : 2'd2;
  assign w_chan = |pa ? win_a : |pb ? win_b : win_c;
  assign irq_valid = state == GRANT;
  assign busy = state != IDLE;
  assign pend_a = |pa;
  assign pend_b = |pb;
  assign pend_c = |pc;
`ifdef IRQ_ARB_ROTATE_EN
  logic [3:0] ptr_a, ptr_b, ptr_c;
  function automatic logic [3:0] pick(input logic [NCH-1:0] p, input logic [3:0] ptr);
    logic [3:0] r;
    logic found;
    int i;
    r = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      i = (int'(ptr) + k) % NCH;
      if (!found && p[i]) begin
        r = 4'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction
  assign win_a = pick(pa, ptr_a);
  assign win_b = pick(pb, ptr_b);
  assign win_c = pick(pc, ptr_c);
  // last-grant pointer of the served bus moves to the channel just released
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_a <= 4'd8;
      ptr_b <= 4'd8;
      ptr_c <= 4'd8;
    end else if (drop) begin
      if (irq_bus == 2'd0) ptr_a <= irq_chan;
      if (irq_bus == 2'd1) ptr_b <= irq_chan;
      if (irq_bus == 2'd2) ptr_c <= irq_chan;
    end
`else
  function automatic logic [3:0] pick(input logic [NCH-1:0] p);
    logic [3:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (p[i]) r = 4'(i);
    return r;
  endfunction
  assign win_a = pick(pa);
  assign win_b = pick(pb);
  assign win_c = pick(pc);
`endif
  // sticky pending bits: a new request beats a same-cycle clear, en low wipes the bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pa <= '0;
      pb <= '0;
      pc <= '0;
    end else begin
      pa <= en & (req_a | (pa & ~ca));
      pb <= en & (req_b | (pb & ~cb));
      pc <= en & (req_c | (pc & ~cc));
    end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next-state: one source per transaction, HOLD then ARB between grants
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = any ? ARB : IDLE;
      ARB:   state_nx = any ? GRANT : IDLE;
      GRANT: state_nx = drop ? HOLD : GRANT;
      HOLD:  state_nx = any ? ARB : IDLE;
    endcase
  end
  // winner is latched in ARB and frozen for the whole grant
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      irq_bus <= '0;
      irq_chan <= '0;
    end else if (state == ARB && any) begin
      irq_bus <= w_bus;
      irq_chan <= w_chan;
    end
  // grant age counter, restarted in ARB and saturating during GRANT
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (state == ARB) cnt <= '0;
    else if (state == GRANT && cnt != '1) cnt <= cnt + 1'b1;
  // forced-drop pulse lands in the HOLD cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) irq_timeout <= 1'b0;
    else irq_timeout <= drop && !irq_ack;
endmodule
